// File: rtl/ehgu_hamming_secded_pkg.sv
// Shared definitions for the ehgu extended-Hamming (SECDED) code.
//   N          : Hamming word length, excluding the overall parity bit
//   K          : data bits per codeword
//   P          : check bits per codeword (N-K)
//   codeword_t : extended codeword, [N-1:0] Hamming word, [N] overall parity
//   SKIP_MASK  : 1 at every index holding a check bit (position 2^j)
//   calc_syndrome / extract_data : pure helpers shared by encoder and decoder
package ehgu_hamming_secded_pkg;

  localparam int N = 7;
  localparam int K = 4;
  localparam int P = N - K;

  typedef logic [N:0]   codeword_t;
  typedef logic [K-1:0] data_t;
  typedef logic [P-1:0] syn_t;

  // Index i holds 1-based position i+1; check bits sit at powers of two.
  function automatic logic [N-1:0] gen_skip_mask();
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < P; j++) begin
      m[(1 << j) - 1] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [N-1:0] SKIP_MASK = gen_skip_mask();

  // Syndrome bit j covers every position whose index has bit j set,
  // the check bit itself included, so a clean word yields zero.
  function automatic syn_t calc_syndrome(input codeword_t code);
    syn_t s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < P; j++) begin
        if (((i + 1) >> j) % 2 == 1) begin
          s[j] = s[j] ^ code[i];
        end
      end
    end
    return s;
  endfunction

  // Data bits are packed from the lowest non-check position upward.
  // Shifting in at the MSB leaves the first data bit found at bit 0.
  function automatic data_t extract_data(input codeword_t code);
    data_t d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (!SKIP_MASK[i]) begin
        d = {code[i], d[K-1:1]};
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ehgu_sat_cnt.sv
// Saturating event counter.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   clr : synchronous clear, wins over a same-cycle increment
//   inc : count one event
//   cnt : current count, holds at all-ones
module ehgu_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ehgu_hamming_secded_dec.sv
// Two-stage streaming SECDED decoder for the ehgu extended Hamming code.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : input handshake; in_code = {overall parity, Hamming word}
//   out_valid/ready : output handshake
//   out_data        : corrected data (uncorrected extraction on double error)
//   out_syn         : raw syndrome
//   out_err_sgl     : single error corrected (including the parity bit itself)
//   out_err_dbl     : uncorrectable error
//   cnt_clr         : clear both status counters
//   cnt_sgl/cnt_dbl : saturating counts of delivered single/double results
// Stage 1 registers codeword, syndrome and overall mismatch; stage 2
// registers the corrected data and flags. One global stall freezes both.
module ehgu_hamming_secded_dec
  import ehgu_hamming_secded_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N:0]    in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_data,
  output logic [P-1:0]  out_syn,
  output logic          out_err_sgl,
  output logic          out_err_dbl,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt_sgl,
  output logic [CW-1:0] cnt_dbl
);

  logic      stall;
  logic      s1_valid;
  codeword_t s1_code;
  syn_t      s1_syn;
  logic      s1_op;

  codeword_t pos_onehot;
  codeword_t fix_code;
  logic      syn_nz;
  logic      syn_in_range;
  logic      nxt_sgl;
  logic      nxt_dbl;
  data_t     nxt_data;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      s1_code <= in_code;
      s1_syn  <= calc_syndrome(in_code);
      s1_op   <= ^in_code;
    end
  end

  // ---------------- stage 2 decode ----------------
  // Bit 'syn' of pos_onehot marks the erroneous position; shifting it down
  // by one maps position to index. A syndrome beyond N shifts out entirely,
  // which is how an out-of-range syndrome is recognised.
  // NOTE: every always_comb output gets a default first so no latch forms.
  always_comb begin
    pos_onehot   = codeword_t'(1) << s1_syn;
    fix_code     = s1_code ^ (pos_onehot >> 1);
    syn_nz       = |s1_syn;
    syn_in_range = |pos_onehot;
    nxt_sgl      = s1_op & (~syn_nz | syn_in_range);
    nxt_dbl      = syn_nz & (~s1_op | ~syn_in_range);
    nxt_data     = extract_data(nxt_sgl ? fix_code : s1_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_syn     <= '0;
      out_err_sgl <= 1'b0;
      out_err_dbl <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= nxt_data;
        out_syn     <= s1_syn;
        out_err_sgl <= nxt_sgl;
        out_err_dbl <= nxt_dbl;
      end
    end
  end

  // ---------------- status counters ----------------
  ehgu_sat_cnt #(.CW(CW)) u_cnt_sgl (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out_valid & out_ready & out_err_sgl),
    .cnt (cnt_sgl)
  );

  ehgu_sat_cnt #(.CW(CW)) u_cnt_dbl (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out_valid & out_ready & out_err_dbl),
    .cnt (cnt_dbl)
  );

endmodule

// File: tb/tb_ehgu_hamming_secded_dec.sv
// Self-checking bench for ehgu_hamming_secded_dec: directed cases followed
// by randomized traffic, scored against a positional Hamming model.
module tb_ehgu_hamming_secded_dec;
  import ehgu_hamming_secded_pkg::*;

  localparam int CWT  = 2;
  localparam int CMAX = (1 << CWT) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N:0]     in_code;
  logic           out_valid;
  logic           out_ready;
  logic [K-1:0]   out_data;
  logic [P-1:0]   out_syn;
  logic           out_err_sgl;
  logic           out_err_dbl;
  logic           cnt_clr;
  logic [CWT-1:0] cnt_sgl;
  logic [CWT-1:0] cnt_dbl;

  always #5 clk = ~clk;

  ehgu_hamming_secded_dec #(.CW(CWT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_syn     (out_syn),
    .out_err_sgl (out_err_sgl),
    .out_err_dbl (out_err_dbl),
    .cnt_clr     (cnt_clr),
    .cnt_sgl     (cnt_sgl),
    .cnt_dbl     (cnt_dbl)
  );

  typedef struct {
    logic [K-1:0] data;
    logic [P-1:0] syn;
    logic         sgl;
    logic         dbl;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   mdl_sgl;
  int   mdl_dbl;
  bit   hold_prev;
  logic [K-1:0] snap_data;
  logic [P-1:0] snap_syn;
  logic snap_sgl;
  logic snap_dbl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_data_pos(input int p);
    return (p & (p - 1)) != 0;
  endfunction

  function automatic logic [N:0] encode(input logic [K-1:0] d);
    logic [N:0]   w;
    logic [K-1:0] dd;
    bit           par;
    w  = '0;
    dd = d;
    for (int p = 1; p <= N; p++) begin
      if (is_data_pos(p)) begin
        w[p-1] = dd[0];
        dd     = dd >> 1;
      end
    end
    for (int c = 1; c <= N; c = c * 2) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if ((p & c) != 0 && p != c) par = par ^ w[p-1];
      end
      w[c-1] = par;
    end
    w[N] = ^w[N-1:0];
    return w;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N:0] w);
    logic [K-1:0] r;
    int           k;
    r = '0;
    k = 0;
    for (int p = 1; p <= N; p++) begin
      if (is_data_pos(p)) begin
        r = r | (K'(w[p-1]) << k);
        k++;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [K-1:0] d, input logic [P-1:0] s,
                              input logic sg, input logic db);
    exp_t e;
    e.data = d;
    e.syn  = s;
    e.sgl  = sg;
    e.dbl  = db;
    return e;
  endfunction

  // force_n < 0 picks 0..2 flipped bits at random. A flip in bit N has
  // position 0, so it contributes nothing to the syndrome.
  task automatic gen(input int force_n, output logic [N:0] w, output exp_t e);
    logic [K-1:0] d;
    int nerr, b1, b2, p1, p2;
    d    = K'($urandom);
    w    = encode(d);
    nerr = (force_n < 0) ? $urandom_range(0, 2) : force_n;
    b1   = $urandom_range(0, N);
    b2   = (b1 + 1 + $urandom_range(0, N - 1)) % (N + 1);
    p1   = (b1 < N) ? b1 + 1 : 0;
    p2   = (b2 < N) ? b2 + 1 : 0;
    e    = mk(d, '0, 1'b0, 1'b0);
    if (nerr == 1) begin
      w[b1] = ~w[b1];
      e.syn = P'(p1);
      e.sgl = 1'b1;
    end else if (nerr == 2) begin
      w[b1]  = ~w[b1];
      w[b2]  = ~w[b2];
      e.syn  = P'(p1 ^ p2);
      e.dbl  = 1'b1;
      e.data = extract(w);
    end
  endtask

  // One clock: checks at the falling edge, model advanced for the coming
  // rising edge, returns 1 ns after it with acc = word accepted.
  task automatic cycle(input exp_t e_in, output bit acc);
    exp_t e;
    @(negedge clk);
    check("cnt_sgl", cnt_sgl, mdl_sgl);
    check("cnt_dbl", cnt_dbl, mdl_dbl);
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (hold_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, snap_data);
      check("hold_syn", out_syn, snap_syn);
      check("hold_sgl", out_err_sgl, snap_sgl);
      check("hold_dbl", out_err_dbl, snap_dbl);
    end
    if (out_valid && out_ready) begin
      check("unexpected_out", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_syn", out_syn, e.syn);
        check("out_err_sgl", out_err_sgl, e.sgl);
        check("out_err_dbl", out_err_dbl, e.dbl);
        if (e.sgl && mdl_sgl < CMAX) mdl_sgl++;
        if (e.dbl && mdl_dbl < CMAX) mdl_dbl++;
      end
    end
    if (cnt_clr) begin
      mdl_sgl = 0;
      mdl_dbl = 0;
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(e_in);
    hold_prev = out_valid && !out_ready;
    snap_data = out_data;
    snap_syn  = out_syn;
    snap_sgl  = out_err_sgl;
    snap_dbl  = out_err_dbl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(mk('0, '0, 1'b0, 1'b0), acc);
  endtask

  task automatic send(input logic [N:0] w, input exp_t e);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_code  = w;
    acc      = 1'b0;
    while (!acc && guard < 50) begin
      cycle(e, acc);
      guard++;
    end
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N:0] w;
    exp_t       e;
    bit         acc;
    bit         pending;
    int         k;
    logic [N:0] bw[4];
    exp_t       be[4];

    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    mdl_sgl = 0; mdl_dbl = 0; hold_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_syn", out_syn, 0);
    check("rst_err_sgl", out_err_sgl, 0);
    check("rst_err_dbl", out_err_dbl, 0);
    check("rst_cnt_sgl", cnt_sgl, 0);
    check("rst_cnt_dbl", cnt_dbl, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Clean word with two-cycle latency
    send(8'h55, mk(4'b1011, 3'd0, 1'b0, 1'b0));
    check("lat_t1_valid", out_valid, 0);
    idle(1);
    check("lat_t2_valid", out_valid, 1);
    idle(1);

    // Single, overall-parity-only and double errors back to back
    send(8'h55 ^ 8'h10, mk(4'b1011, 3'd5, 1'b1, 1'b0));
    send(8'h55 ^ 8'h80, mk(4'b1011, 3'd0, 1'b1, 1'b0));
    send(8'h55 ^ 8'h03, mk(4'b1011, 3'd3, 1'b0, 1'b1));
    idle(3);
    check("dir_cnt_sgl", cnt_sgl, 2);
    check("dir_cnt_dbl", cnt_dbl, 1);

    // Backpressure: four words, out_ready low for three cycles mid-stream
    for (int i = 0; i < 4; i++) begin
      gen(-1, w, e);
      bw[i] = w;
      be[i] = e;
    end
    k = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = (k < 4);
      in_code   = bw[(k < 4) ? k : 0];
      out_ready = !(i >= 3 && i <= 5);
      cycle(be[(k < 4) ? k : 0], acc);
      if (acc) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("bp_accepted", k, 4);
    check("bp_drained", sb.size(), 0);

    // Saturation of the single-error counter
    for (int i = 0; i < 5; i++) begin
      gen(1, w, e);
      send(w, e);
    end
    idle(3);
    check("cnt_sgl_sat", cnt_sgl, CMAX);

    // Clear coincident with a delivered single error
    gen(1, w, e);
    send(w, e);
    idle(1);
    check("clr_pre_valid", out_valid, 1);
    check("clr_pre_sgl", out_err_sgl, 1);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check("clr_cnt_sgl", cnt_sgl, 0);

    // Reset with both stages full
    for (int i = 0; i < 2; i++) begin
      gen(1, w, e);
      in_valid = 1'b1;
      in_code  = w;
      cycle(e, acc);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    mdl_sgl   = 0;
    mdl_dbl   = 0;
    hold_prev = 1'b0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_cnt_sgl", cnt_sgl, 0);
    idle(1);
    check("mrst_s1_flushed", out_valid, 0);
    idle(1);

    // Randomized traffic with random backpressure and occasional clears
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        gen(-1, w, e);
        pending = 1'b1;
      end
      in_valid  = pending;
      in_code   = pending ? w : (N + 1)'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      cycle(e, acc);
      if (acc) pending = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    idle(4);
    check("rand_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
